fifo_bus_arbiter: RTL
=====================

# fifo_bus_arbiter

Round-robin, packet-locked arbiter that produces the per-FD bus-select vectors driven into `bus_sel_bits_interconnect`. Each of the PORT_NUM output FIFOs has its own arbiter. The arbiter picks one requesting FD, holds that grant until the FD signals end-of-packet, then releases the FIFO. Grants are emitted in FD-major order, so FD x's slice connects directly to `fd_x_bus_sel`.

## Interface
- PORT_NUM, 14, number of FDs and number of FIFOs.
- TIMEOUT_CYC, 1024, watchdog limit in cycles; used only with BUS_ARB_TIMEOUT_EN.
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  PORT_NUM*PORT_NUM  bit [x*PORT_NUM+y] means FD x requests FIFO y.
- fd_eop  input  PORT_NUM  bit x pulses for one cycle on the last beat of FD x's packet.
- fifo_full  input  PORT_NUM  bit y high means FIFO y cannot start a new packet.
- grant  output  PORT_NUM*PORT_NUM  bit [x*PORT_NUM+y] means FD x owns FIFO y; slice x drives `fd_x_bus_sel`.
- fifo_busy  output  PORT_NUM  bit y high means FIFO y is locked to an FD.
- timeout  output  PORT_NUM  bit y pulses for one cycle when FIFO y's lock is force-released.

## Operation
- There is one independent arbiter per FIFO y. Each arbiter has a 2-state FSM (IDLE, BUSY) and a round-robin pointer ptr_y of width clog2(PORT_NUM).
- IDLE, when fifo_full[y]=0 and at least one req[x*PORT_NUM+y] is set:
  - Select the first requesting x, searching upward from ptr_y with wrap modulo PORT_NUM.
  - Set the grant bit, go to BUSY, and set ptr_y = (x+1) mod PORT_NUM.
  - ptr_y wraps from PORT_NUM-1 to 0.
- IDLE with fifo_full[y]=1: no grant is issued, state and pointer are unchanged, and requests keep waiting.
- BUSY:
  - The grant is held regardless of req, fifo_full, or other FDs' requests.
  - fd_eop[x] from the owner clears the grant and returns the FSM to IDLE.
  - fd_eop from a non-owner is ignored.
- One fd_eop[x] releases every FIFO that FD x currently owns.
- An FD may own several FIFOs at once (multicast). Each FIFO's arbitration is independent.
- Invariant: every FIFO slice has at most one grant bit set (one-hot or zero).
- fifo_busy[y] = (state_y == BUSY).
- Reset mid-packet: every grant drops immediately (asynchronous), FSMs go to IDLE, pointers go to 0. No eop is required afterwards.
- Reset values: grant=0, fifo_busy=0, timeout=0, ptr=0, timeout counters=0.

## Timing
- Grants are registered. A request sampled in IDLE at edge N makes the grant visible after edge N, so latency is 1 cycle.
- fd_eop sampled at edge M clears the grant after edge M. The eop beat itself still sees the grant high.
- There is a one-cycle IDLE bubble after release. The earliest re-grant of the same FIFO is visible after edge M+1.
- fifo_full is evaluated only in IDLE, in the same cycle as the request.
- If a request and the owner's eop arrive in the same cycle, the release wins and the request is arbitrated in the following IDLE cycle.

## Configuration
- BUS_ARB_TIMEOUT_EN defined:
  - Each FIFO has a counter that clears on grant and increments each BUSY cycle.
  - When the counter reaches TIMEOUT_CYC with no owner eop, the grant is cleared, the FSM returns to IDLE, and timeout[y] pulses for 1 cycle.
  - ptr_y keeps the value set at grant time.
  - An eop in the same cycle as expiry counts as a normal release; timeout stays 0.
- BUS_ARB_TIMEOUT_EN undefined: no counters are built, timeout is tied to 0, and locks are held indefinitely until eop.

## Test plan
- Reset and single grant:
  - Assert rst, then release it. Raise req[3*14+5].
  - Required: grant[3*14+5]=1 one cycle later and fifo_busy[5]=1. All outputs read 0 during reset.
- Round-robin contention:
  - FDs 2, 7 and 9 request FIFO 0 continuously, and each owner pulses eop 4 cycles after its grant.
  - Required grant order: 2, 7, 9, 2, with one IDLE bubble cycle between consecutive owners.
- Lock and full:
  - While FD 1 owns FIFO 4, drop req, raise fifo_full[4], and raise FD 6's request. Required: the grant to FD 1 is held and FD 6 is not granted.
  - After eop[1] with fifo_full[4] still 1: no grant is issued.
  - After fifo_full[4] drops: FD 6 is granted 1 cycle later.
- Multicast release:
  - FD 0 requests FIFOs 1, 2 and 3 and owns all three.
  - A single fd_eop[0] pulse clears all three grants on the same edge.
  - fd_eop[5] from a non-owner never alters FIFO 1.
- Reset mid-packet: assert rst while FIFO 8 is BUSY. Required: grant drops asynchronously, and after reset the next grant for FIFO 8 searches from pointer 0.
- Timeout (macro defined, TIMEOUT_CYC=16):
  - The owner of FIFO 10 never sends eop.
  - Required: the grant clears 16 BUSY cycles after it was granted, timeout[10] pulses 1 cycle, and a pending requester is granted after the bubble.
  - With the macro undefined: the grant holds for more than 1000 cycles.

Source files
------------

// File: rtl/fifo_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bus_arbiter_if
// Brief    : Request/grant bundle between the FDs and the per-FIFO arbiters.
// Revision : 1.0
// ============================================================================
interface fifo_bus_arbiter_if #(
  parameter int PORT_NUM = 14
);
  logic [PORT_NUM*PORT_NUM-1:0] req;
  logic [PORT_NUM-1:0]          fd_eop;
  logic [PORT_NUM-1:0]          fifo_full;
  logic [PORT_NUM*PORT_NUM-1:0] grant;
  logic [PORT_NUM-1:0]          fifo_busy;
  logic [PORT_NUM-1:0]          timeout;

  modport master (
    output req, fd_eop, fifo_full,
    input  grant, fifo_busy, timeout
  );

  modport slave (
    input  req, fd_eop, fifo_full,
    output grant, fifo_busy, timeout
  );
endinterface
`default_nettype wire

// File: rtl/fifo_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : fifo_bus_arbiter
// Brief    : Per-FIFO round-robin, packet-locked arbiters driving the FD-major
//            bus-select grant vector. Optional watchdog: BUS_ARB_TIMEOUT_EN.
// Revision : 1.0
// ============================================================================
module fifo_bus_arbiter #(
  parameter int PORT_NUM    = 14,
  parameter int TIMEOUT_CYC = 1024
) (
  input wire logic           clk,
  input wire logic           rst,
  fifo_bus_arbiter_if.slave  bus
);

  localparam int       c_ptr_w   = (PORT_NUM > 1) ? $clog2(PORT_NUM) : 1;
  localparam bit [0:0] c_st_idle = 1'b0;
  localparam bit [0:0] c_st_busy = 1'b1;

  // (base + off) mod PORT_NUM, for off < PORT_NUM
  function automatic logic [c_ptr_w-1:0] f_wrap_add(
    input logic [c_ptr_w-1:0] base,
    input int                 off
  );
    int s;
    s = int'(base) + off;
    if (s >= PORT_NUM) s = s - PORT_NUM;
    return s[c_ptr_w-1:0];
  endfunction

`ifndef BUS_ARB_TIMEOUT_EN
  localparam int c_unused_timeout = TIMEOUT_CYC;
`endif

  genvar gy, gx;
  generate
    for (gy = 0; gy < PORT_NUM; gy++) begin : g_fifo
      logic [PORT_NUM-1:0] w_req_col;
      logic [PORT_NUM-1:0] r_owner;
      logic [PORT_NUM-1:0] w_owner_nxt;
      logic [c_ptr_w-1:0]  r_ptr;
      logic [c_ptr_w-1:0]  w_ptr_nxt;
      logic [0:0]          r_state;
      logic [0:0]          w_state_nxt;
      logic [c_ptr_w-1:0]  w_pick_idx;
      logic                w_found;
      logic                w_grant_go;
      logic                w_owner_eop;
      logic                w_expire;

      for (gx = 0; gx < PORT_NUM; gx++) begin : g_col
        assign w_req_col[gx]                  = bus.req[gx*PORT_NUM+gy];
        assign bus.grant[gx*PORT_NUM+gy]      = r_owner[gx];
      end

      // First requester at or above the pointer, wrapping modulo PORT_NUM.
      always_comb begin
        w_found    = 1'b0;
        w_pick_idx = '0;
        for (int i = 0; i < PORT_NUM; i++) begin
          if (!w_found && w_req_col[f_wrap_add(r_ptr, i)]) begin
            w_found    = 1'b1;
            w_pick_idx = f_wrap_add(r_ptr, i);
          end
        end
      end

      assign w_grant_go  = w_found && !bus.fifo_full[gy];
      assign w_owner_eop = |(r_owner & bus.fd_eop);

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_state <= c_st_idle;
          r_owner <= '0;
          r_ptr   <= '0;
        end else begin
          r_state <= w_state_nxt;
          r_owner <= w_owner_nxt;
          r_ptr   <= w_ptr_nxt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        case (r_state)
          c_st_idle: if (w_grant_go)               w_state_nxt = c_st_busy;
          c_st_busy: if (w_owner_eop || w_expire)  w_state_nxt = c_st_idle;
          default:                                 w_state_nxt = c_st_idle;
        endcase
      end

      always_comb begin
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
          c_st_idle: begin
            if (w_grant_go) begin
              w_owner_nxt = {{(PORT_NUM-1){1'b0}}, 1'b1} << w_pick_idx;
              w_ptr_nxt   = f_wrap_add(w_pick_idx, 1);
            end
          end
          c_st_busy: begin
            if (w_owner_eop || w_expire) w_owner_nxt = '0;
          end
          default: w_owner_nxt = '0;
        endcase
      end

      assign bus.fifo_busy[gy] = (r_state == c_st_busy);

`ifdef BUS_ARB_TIMEOUT_EN
      localparam int c_cnt_w = $clog2(TIMEOUT_CYC + 1);
      logic [c_cnt_w-1:0] r_cnt;
      logic               r_timeout;

      // Counter reads N after N BUSY edges; expiry releases on the TIMEOUT_CYC-th.
      assign w_expire = (r_state == c_st_busy) &&
                        (r_cnt == c_cnt_w'(TIMEOUT_CYC - 1));

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_cnt     <= '0;
          r_timeout <= 1'b0;
        end else begin
          r_timeout <= w_expire && !w_owner_eop;
          if (r_state == c_st_busy) r_cnt <= r_cnt + 1'b1;
          else                      r_cnt <= '0;
        end
      end

      assign bus.timeout[gy] = r_timeout;
`else
      assign w_expire        = 1'b0;
      assign bus.timeout[gy] = 1'b0;
`endif
    end
  endgenerate

endmodule
`default_nettype wire
